// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if
//   Write-side bundle between the FIFO write client and fifo_wr_ctrl.
//   master : write client (drives w_inc, clr_ovf, and the synchronized
//            read pointer r_ptr_sync)
//   slave  : fifo_wr_ctrl (drives w_en, w_addr, w_ptr, full, almost_full,
//            w_level, overflow)
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  w_inc;
    logic [ADDR_WIDTH:0]   r_ptr_sync;
    logic                  clr_ovf;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH:0]   w_ptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   w_level;
    logic                  overflow;

    modport master (
        output w_inc, r_ptr_sync, clr_ovf,
        input  w_en, w_addr, w_ptr, full, almost_full, w_level, overflow
    );

    modport slave (
        input  w_inc, r_ptr_sync, clr_ovf,
        output w_en, w_addr, w_ptr, full, almost_full, w_level, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
//   Write-domain pointer and flag controller for an asynchronous FIFO.
//   Accepts write requests, produces the memory write address/enable, keeps
//   the Gray write pointer for the read-domain synchronizer, and derives
//   full / almost_full / fill level / sticky overflow from the synchronized
//   Gray read pointer.
//
// Ports
//   clk          write-domain clock
//   rst          asynchronous, active-low reset
//   bus (slave)  w_inc, r_ptr_sync, clr_ovf in;
//                w_en (comb), w_addr, w_ptr, full, almost_full, w_level,
//                overflow out
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic          clk,
    input  logic          rst,
    fifo_wr_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] w_gray;
    logic          full_q;
    logic          af_q;
    logic [PW-1:0] level_q;
    logic          ovf_q;

    logic          accept;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          af_next;
    logic          ovf_next;

    always_comb begin
        accept      = bus.w_inc & ~full_q;
        wbin_next   = wbin + PW'(accept);
        w_gray_next = wbin_next ^ (wbin_next >> 1);

        // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
        rbin = bus.r_ptr_sync;
        for (int unsigned i = 2; i <= PW; i++) begin
            rbin[PW-i] = rbin[PW-i+1] ^ bus.r_ptr_sync[PW-i];
        end

        level_next = wbin_next - rbin;
        // In Gray space "one full lap ahead" means the two MSBs differ and the
        // rest match; equivalent to level_next == DEPTH.
        full_next  = (w_gray_next == {~bus.r_ptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                                      bus.r_ptr_sync[ADDR_WIDTH-2:0]});
        af_next    = (level_next >= AF_LVL);
        // A new overflow event takes priority over a simultaneous clear.
        ovf_next   = (bus.w_inc & full_q) | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin    <= '0;
            w_gray  <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            w_gray  <= w_gray_next;
            full_q  <= full_next;
            af_q    <= af_next;
            level_q <= level_next;
            ovf_q   <= ovf_next;
        end
    end

    assign bus.w_en        = accept;
    assign bus.w_addr      = wbin[ADDR_WIDTH-1:0];
    assign bus.w_ptr       = w_gray;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.w_level     = level_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
//   Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=4, AF_THRESH=12).
//   Reference model counts accepted writes and read-side words as plain
//   integers; the FIFO fill is their difference.
module tb_fifo_wr_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    // reference model state
    int wr_cnt = 0;   // total accepted writes since reset
    int rd_cnt = 0;   // read count currently presented on r_ptr_sync
    int m_level = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;
    bit exp_wen;
    int exp_addr;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [12:0] exp_regs();
        return {gray(wr_cnt), m_full, m_af, 5'(m_level), m_ovf};
    endfunction

    function automatic logic [12:0] got_regs();
        return {bus.w_ptr, bus.full, bus.almost_full, bus.w_level, bus.overflow};
    endfunction

    task automatic model_reset();
        wr_cnt = 0; rd_cnt = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    // Apply inputs for the coming cycle and predict the combinational outputs.
    task automatic set_in(input bit inc, input int rd, input bit clr);
        bus.w_inc      = inc;
        rd_cnt         = rd;
        bus.r_ptr_sync = gray(rd);
        bus.clr_ovf    = clr;
        #1;
        exp_wen  = inc && !m_full;
        exp_addr = wr_cnt % DEPTH;
    endtask

    // Clock edge: advance the model with the inputs currently applied.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc     = bus.w_inc && !m_full;
        m_ovf   = (bus.w_inc && m_full) || (m_ovf && !bus.clr_ovf);
        wr_cnt  = wr_cnt + int'(acc);
        m_level = wr_cnt - rd_cnt;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AFT);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_in(0, 0, 0);
        #1 rst = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({bus.w_en, bus.w_addr, got_regs()} !== 18'd0) begin
            failed++;
            $display("FAIL reset_state got %h exp 0", {bus.w_en, bus.w_addr, got_regs()});
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            set_in(1, 0, 0);
            tests_run++;
            if (bus.w_en !== 1'b1 || int'(bus.w_addr) != exp_addr || exp_addr != i - 1) begin
                failed++;
                $display("FAIL fill_addr[%0d] got en=%b addr=%0d exp en=1 addr=%0d", i, bus.w_en, bus.w_addr, i - 1);
            end
            tick();
            tests_run++;
            if (got_regs() !== exp_regs() || bus.almost_full !== (i >= AFT) || bus.full !== (i == DEPTH)) begin
                failed++;
                $display("FAIL fill_regs[%0d] got %h exp %h", i, got_regs(), exp_regs());
            end
        end
        tests_run++;
        if (bus.w_ptr !== 5'b11000 || bus.w_level !== 5'd16) begin
            failed++;
            $display("FAIL full_ptr got ptr=%b lvl=%0d exp ptr=11000 lvl=16", bus.w_ptr, bus.w_level);
        end
        set_in(1, 0, 0);
        tests_run++;
        if (bus.w_en !== 1'b0) begin
            failed++;
            $display("FAIL drop_wen got %b exp 0", bus.w_en);
        end
        tick();
        tests_run++;
        if (bus.overflow !== 1'b1 || bus.w_ptr !== 5'b11000 || got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL drop_ovf got %h exp %h", got_regs(), exp_regs());
        end
    endtask

    task automatic test_free_slot();
        set_in(0, 1, 0);
        tick();
        tests_run++;
        if (bus.full !== 1'b0 || bus.w_level !== 5'd15 || got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL free_slot got full=%b lvl=%0d exp full=0 lvl=15", bus.full, bus.w_level);
        end
        set_in(1, 1, 0);
        tests_run++;
        if (bus.w_en !== 1'b1 || int'(bus.w_addr) != exp_addr) begin
            failed++;
            $display("FAIL refill_wen got en=%b addr=%0d exp en=1 addr=%0d", bus.w_en, bus.w_addr, exp_addr);
        end
        tick();
        tests_run++;
        if (bus.full !== 1'b1 || got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL refill_full got %h exp %h", got_regs(), exp_regs());
        end
    endtask

    task automatic test_overflow();
        set_in(0, 1, 1);
        tick();
        tests_run++;
        if (bus.overflow !== 1'b0 || got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL ovf_clear got ovf=%b exp 0", bus.overflow);
        end
        set_in(1, 1, 0);
        tick();
        tests_run++;
        if (bus.overflow !== 1'b1) begin
            failed++;
            $display("FAIL ovf_set got %b exp 1", bus.overflow);
        end
        set_in(1, 1, 1);
        tick();
        tests_run++;
        if (bus.overflow !== 1'b1 || got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL ovf_set_wins got ovf=%b exp 1", bus.overflow);
        end
        set_in(0, 1, 1);
        tick();
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        bit wrapped = 0;
        int bad = 0;
        test_reset();
        prev = bus.w_ptr;
        for (int i = 0; i < 40; i++) begin
            // read side trails so that the fill settles at 4 words
            set_in(1, (wr_cnt >= 3) ? wr_cnt - 3 : 0, 0);
            tick();
            if ($countones(prev ^ bus.w_ptr) != 1) bad++;
            if (bus.w_ptr == 5'd0) wrapped = 1;
            if (bus.full !== 1'b0) bad++;
            if (i >= 3 && bus.w_level !== 5'd4) bad++;
            if (got_regs() !== exp_regs()) bad++;
            prev = bus.w_ptr;
        end
        tests_run++;
        if (bad != 0 || !wrapped) begin
            failed++;
            $display("FAIL wrap got bad=%0d wrapped=%0b exp bad=0 wrapped=1", bad, wrapped);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            bit inc = ($urandom_range(0, 3) != 0);
            bit clr = ($urandom_range(0, 9) == 0);
            int rd  = rd_cnt + ((i % 3 == 0) ? int'($urandom_range(0, 2)) : 0);
            if (rd > wr_cnt) rd = wr_cnt;
            set_in(inc, rd, clr);
            if (bus.w_en !== exp_wen || int'(bus.w_addr) != exp_addr) bad++;
            tick();
            if (got_regs() !== exp_regs()) begin
                if (bad < 3)
                    $display("FAIL random_regs[%0d] got %h exp %h", i, got_regs(), exp_regs());
                bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL random got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        test_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 0);
            tick();
        end
        tests_run++;
        if (got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL pre_reset got %h exp %h", got_regs(), exp_regs());
        end
        set_in(0, 0, 0);
        #1 rst = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({bus.w_en, bus.w_addr, got_regs()} !== 18'd0) begin
            failed++;
            $display("FAIL mid_reset got %h exp 0", {bus.w_en, bus.w_addr, got_regs()});
        end
        @(negedge clk) rst = 1'b1;
        set_in(1, 0, 0);
        tests_run++;
        if (bus.w_en !== 1'b1 || bus.w_addr !== 4'd0) begin
            failed++;
            $display("FAIL post_reset_addr got en=%b addr=%0d exp en=1 addr=0", bus.w_en, bus.w_addr);
        end
        tick();
        tests_run++;
        if (got_regs() !== exp_regs()) begin
            failed++;
            $display("FAIL post_reset_regs got %h exp %h", got_regs(), exp_regs());
        end
    endtask

    initial begin
        bus.w_inc = 1'b0;
        bus.r_ptr_sync = '0;
        bus.clr_ovf = 1'b0;
        test_reset();
        test_fill();
        test_free_slot();
        test_overflow();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO. Accepts write requests and produces the memory write address and enable. Maintains the Gray-coded write pointer that the read-domain double-flop synchronizer consumes. Takes the already-synchronized Gray read pointer from the write-domain synchronizer and derives full, almost-full, fill level and a sticky overflow flag.

## Interface

Parameters:
- ADDR_WIDTH, 4, memory address width; depth DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AF_THRESH, 12, almost_full asserts when fill level >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  reset; asynchronous, active-low.
- w_inc  input  1  write request; one word per cycle while high.
- r_ptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into the clk domain.
- clr_ovf  input  1  clears overflow.
- w_en  output  1  memory write enable, combinational: w_inc & ~full.
- w_addr  output  ADDR_WIDTH  memory write address: low ADDR_WIDTH bits of the binary write pointer.
- w_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- full  output  1  registered full flag.
- almost_full  output  1  registered; high when level >= AF_THRESH.
- w_level  output  ADDR_WIDTH+1  registered fill level as seen from the write side, 0..DEPTH.
- overflow  output  1  sticky; set by a write attempted while full.

## Operation

- State registers: binary write pointer wbin, Gray pointer w_ptr, full, almost_full, w_level, overflow. All are clocked on posedge clk.
- Reset (rst low, asynchronous): wbin=0, w_ptr=0, full=0, almost_full=0, w_level=0, overflow=0. w_en therefore reads 0 unless w_inc is high.
- Write acceptance: a write is accepted when w_inc=1 and full=0; the write is the same cycle w_en=1.
  - wbin_next = wbin + accepted, computed modulo 2^(ADDR_WIDTH+1); wrap from all-ones to 0 is natural.
  - w_ptr_next = wbin_next ^ (wbin_next >> 1).
- Read pointer decode: rbin = Gray-to-binary of r_ptr_sync, computed combinationally by a prefix XOR from the MSB.
- Full: full_next = (w_ptr_next == {~r_ptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], r_ptr_sync[ADDR_WIDTH-2:0]}). This compares the two MSBs inverted and the rest equal.
- Level: w_level_next = wbin_next - rbin, modulo 2^(ADDR_WIDTH+1).
  - full_next is equivalent to w_level_next == DEPTH; both forms must agree.
- Almost full: almost_full_next = (w_level_next >= AF_THRESH).
- Write while full: w_inc=1 with full=1 is dropped. w_en=0 and the pointer does not move.
- Overflow: overflow_next = (w_inc & full) | (overflow & ~clr_ovf).
  - If a set and clr_ovf occur in the same cycle, the set wins.
- Read-side lag: the level is conservative, because r_ptr_sync lags the true read pointer by the synchronizer latency. full and almost_full may stay high after reads until the new r_ptr_sync arrives; this is correct behaviour, not an error.
- Reset mid-operation: all state clears immediately, regardless of the clock. The read domain must be reset in the same event; that is a system-level requirement.

## Timing

- w_en and w_addr are valid in the same cycle as w_inc; memory captures at the clk edge ending that cycle.
- w_ptr, w_level, full, almost_full and overflow update at the edge that accepts the write: 1-cycle latency.
- full deasserts 1 cycle after r_ptr_sync changes to a value that frees a slot.
- Filling an empty FIFO takes DEPTH consecutive accepted writes. full rises at the edge of the DEPTH-th write, so the DEPTH+1-th request in the next cycle is dropped.
- w_ptr changes at most one bit per clk edge.

## Test plan

- Reset, then 16 consecutive w_inc with r_ptr_sync=0 (ADDR_WIDTH=4, AF_THRESH=12):
  - w_addr runs 0..15;
  - almost_full rises after the 12th write;
  - full rises after the 16th with w_level=16 and w_ptr=5'b11000;
  - the 17th request gives w_en=0 and overflow=1 the next cycle.
- From full, set r_ptr_sync=5'b00001 (rbin=1) -> full=0 and w_level=15 one cycle later; one write is then accepted and full returns.
- Wrap-around, driving r_ptr_sync to track the write pointer with a lag of 4:
  - run 40 writes;
  - w_level stays at 4, w_ptr wraps through 0;
  - Hamming distance of every w_ptr change is 1;
  - full is never asserted.
- Overflow handling:
  - with overflow=1, pulse clr_ovf -> overflow=0 next cycle;
  - assert w_inc with full=1 and clr_ovf=1 in the same cycle -> overflow stays 1.
- Mid-operation reset: assert rst low between clock edges after 7 writes. All outputs go 0 immediately, without waiting for a clock edge. After release, the first write uses w_addr=0.
